// File: rtl/ram_stream_reader.sv
// Streams a burst of words from a fixed-latency RAM into a valid/ready output.
// A small credit-checked FIFO absorbs the RAM latency and downstream stalls.
module ram_stream_reader #(
  parameter int DW         = 272,
  parameter int AW         = 8,
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addrb,
  input  logic [DW-1:0] ram_doutb,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(RD_LAT + 1);
  localparam int SW = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW:0]     rem_q, rem_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [DW-1:0]   fifo_q [FIFO_DEPTH];

  logic            issue;
  logic            wr;
  logic            pop;
  logic            credit;
  logic [IW-1:0]   inflight;
  logic [IW-1:0]   inflight_d;
  logic [RD_LAT:0] tag_sh;

  assign ram_addrb = addr_q;
  assign m_valid   = (cnt_q != '0);
  assign m_data    = fifo_q[rptr_q];
  assign wr        = tag_q[RD_LAT-1];
  assign pop       = m_valid && m_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + IW'(tag_q[i]);
    end
  end

  // Every tagged read already owns a FIFO slot, so writes never overflow.
  assign credit = (SW'(cnt_q) + SW'(inflight)) < SW'(FIFO_DEPTH);

  always_comb begin
    issue = 1'b0;
    if (state_q == S_READ && rem_q != '0 && credit) begin
      issue = 1'b1;
    end
  end

  always_comb begin
    tag_sh = {tag_q, issue};
    tag_d  = tag_sh[RD_LAT-1:0];
    inflight_d = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_d = inflight_d + IW'(tag_d[i]);
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    unique case (1'b1)
      (wr && !pop): cnt_d = cnt_q + CW'(1);
      (pop && !wr): cnt_d = cnt_q - CW'(1);
      default:      cnt_d = cnt_q;
    endcase
    if (wr) begin
      wptr_d = (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = S_READ;
            addr_d  = base_addr;
            rem_d   = len;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        busy = 1'b1;
        if (issue) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Leave as the final word is accepted so done follows it directly.
        if (inflight_d == '0 && cnt_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      fifo_q[wptr_q] <= ram_doutb;
    end
  end

endmodule
